// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: opcodes, the fetch FSM
// state encoding, the default reset vector and a sign-extension helper.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Reset vector used when the instantiating design does not override it
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  // Sign-extend a 16-bit immediate to a 32-bit word
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: sequential, taken branch or absolute jump.
// Purely combinational so it can also sit in a single-cycle datapath.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  logic [31:0] signimm;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Candidate targets; all arithmetic wraps modulo 2^32
  always_comb begin
    pcplus4       = pc + 32'd4;
    signimm       = sign_ext16(instr[15:0]);
    branch_target = pcplus4 + {signimm[29:0], 2'b00};
    jump_target   = {pcplus4[31:28], instr[25:0], 2'b00};
  end

  // Select the target; a jump overrides a taken branch
  always_comb begin
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end else begin
      next_pc = pcplus4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, requests one word at a time from
// instruction memory and holds the returned instruction under valid/ready
// until the downstream controller accepts it. No speculation: the next
// request is only issued once the controller has resolved pcsrc/jump.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4,
  input  logic             pcsrc,
  input  logic             jump
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pcplus4_w;
  logic [WIDTH-1:0] next_pc_w;

  // Target computation for the instruction currently held in instr_q
  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (instr_q),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .pcplus4 (pcplus4_w),
    .next_pc (next_pc_w)
  );

  // State register; reset abandons any outstanding fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one fetch outstanding, then hold until accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack)    state_d = ISSUE;
      ISSUE:   if (instr_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state plus the held registers
  always_comb begin
    imem_req    = (state_q == FETCH);
    instr_valid = (state_q == ISSUE);
    imem_addr   = pc_q;
    instr       = instr_q;
    op          = instr_q[31:26];
    funct       = instr_q[5:0];
    pc          = pc_q;
    pcplus4     = pcplus4_w;
  end

  // Datapath updates: capture only on an ack in FETCH, advance PC only on accept
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if ((state_q == FETCH) && imem_ack) begin
      instr_d = imem_rdata;
    end
    if ((state_q == ISSUE) && instr_ready) begin
      pc_d = next_pc_w;
    end
  end

  // PC and instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory responder pushes every returned
// word into a queue, a consumer/monitor pops and checks it when the DUT
// presents it, and a reference model predicts each following fetch address.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;

  ifetch_unit #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .pcsrc       (pcsrc),
    .jump        (jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;

  typedef struct {
    logic [31:0] data;
    logic        pcsrc;
    logic        jump;
    int          lat;
    int          hold;
    logic [31:0] nxt;
  } dir_t;

  localparam int N_DIR = 13;
  dir_t tbl [N_DIR];

  fetch_t      sb[$];
  logic [31:0] addr_q[$];

  int vectors = 0;
  int miscompares = 0;
  int mem_idx = 0;
  int con_idx = 0;
  int accepts = 0;
  int ack_cyc = 0;
  bit busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address from the architectural rules
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [31:0] d,
                                             input logic ps, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = a + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((d & 32'h03FF_FFFF) * 32'd4);
    if (ps) begin
      off = int'($signed(d[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Memory responder: checks request address, returns data after a latency
  initial begin : mem_proc
    logic [31:0] cur_addr;
    logic [31:0] exp_a;
    logic [31:0] data;
    int          lat;
    cur_addr = '0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        imem_ack = 1'b0;
        busy = 0;
        continue;
      end
      if (imem_req) begin
        if (!busy) begin
          if (addr_q.size() == 0) begin
            chk("req_unexpected", {31'd0, imem_req}, 32'd0);
          end else begin
            exp_a = addr_q.pop_front();
            chk("fetch_addr", imem_addr, exp_a);
          end
          cur_addr = imem_addr;
          busy = 1;
          lat = (mem_idx < N_DIR) ? tbl[mem_idx].lat : int'($urandom_range(0, 3));
        end else begin
          chk("addr_stable", imem_addr, cur_addr);
        end
        if (lat == 0) begin
          data = (mem_idx < N_DIR) ? tbl[mem_idx].data : 32'($urandom);
          imem_ack = 1'b1;
          imem_rdata = data;
          sb.push_back('{addr: cur_addr, data: data});
          ack_cyc = int'($time / 10);
          busy = 0;
          mem_idx++;
          $display("fetch  addr=%h data=%h", cur_addr, data);
        end else begin
          lat--;
          imem_ack = 1'b0;
          imem_rdata = 32'($urandom);
        end
      end else begin
        if (busy) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          busy = 0;
        end
        // Stray acks outside FETCH must be ignored by the DUT
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = 32'($urandom);
      end
    end
  end

  // Consumer and monitor: checks the presented instruction, applies backpressure
  initial begin : con_proc
    fetch_t      e;
    bit          started;
    bit          expect_req;
    int          hold;
    logic        ps, jp;
    logic [31:0] nxt;
    started = 0;
    expect_req = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        instr_ready = 1'b0;
        started = 0;
        expect_req = 0;
        continue;
      end
      if (expect_req) begin
        chk("req_after_accept", {31'd0, imem_req}, 32'd1);
        expect_req = 0;
      end
      if (instr_valid) begin
        if (sb.size() == 0) begin
          chk("valid_unexpected", {31'd0, instr_valid}, 32'd0);
          instr_ready = 1'b0;
        end else begin
          e = sb[0];
          if (!started) begin
            started = 1;
            chk("valid_latency", 32'($time / 10), 32'(ack_cyc + 1));
            hold = (con_idx < N_DIR) ? tbl[con_idx].hold : int'($urandom_range(0, 2));
          end
          chk("instr", instr, e.data);
          chk("pc", pc, e.addr);
          chk("pcplus4", pcplus4, e.addr + 32'd4);
          chk("op", {26'd0, op}, {26'd0, e.data[31:26]});
          chk("funct", {26'd0, funct}, {26'd0, e.data[5:0]});
          chk("req_low_in_issue", {31'd0, imem_req}, 32'd0);
          if (hold == 0) begin
            if (con_idx < N_DIR) begin
              ps = tbl[con_idx].pcsrc;
              jp = tbl[con_idx].jump;
              nxt = tbl[con_idx].nxt;
            end else begin
              ps = 1'($urandom_range(0, 1));
              jp = 1'($urandom_range(0, 3) == 0);
              nxt = model_next(e.addr, e.data, ps, jp);
            end
            instr_ready = 1'b1;
            pcsrc = ps;
            jump = jp;
            addr_q.push_back(nxt);
            void'(sb.pop_front());
            started = 0;
            expect_req = 1;
            con_idx++;
            accepts++;
            $display("accept pc=%h instr=%h pcsrc=%0d jump=%0d next=%h", e.addr, e.data, ps, jp, nxt);
          end else begin
            hold--;
            instr_ready = 1'b0;
            pcsrc = 1'($urandom_range(0, 1));
            jump = 1'($urandom_range(0, 1));
          end
        end
      end else begin
        instr_ready = 1'($urandom_range(0, 1));
        pcsrc = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : main_proc
    int target;
    tbl = '{
      '{32'h0000_0020, 1'b0, 1'b0, 0, 0, 32'h0000_0004},
      '{32'h2008_0005, 1'b0, 1'b0, 0, 0, 32'h0000_0008},
      '{32'h1000_0003, 1'b1, 1'b0, 3, 0, 32'h0000_0018},
      '{32'h0800_0002, 1'b0, 1'b1, 0, 0, 32'h0000_0008},
      '{32'h1000_FFFF, 1'b1, 1'b0, 0, 0, 32'h0000_0008},
      '{32'h1000_FFFF, 1'b0, 1'b0, 0, 4, 32'h0000_000C},
      '{32'h0800_0000, 1'b0, 1'b1, 2, 0, 32'h0000_0000},
      '{32'h0800_0010, 1'b0, 1'b1, 0, 0, 32'h0000_0040},
      '{32'h0800_0000, 1'b0, 1'b1, 0, 0, 32'h0000_0000},
      '{32'h0800_0010, 1'b1, 1'b1, 0, 0, 32'h0000_0040},
      '{32'h1000_8000, 1'b1, 1'b0, 0, 0, 32'hFFFE_0044},
      '{32'h1000_7FED, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC},
      '{32'h8C08_0000, 1'b0, 1'b0, 1, 0, 32'h0000_0000}
    };

    // Power-on reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    addr_q.push_back(RST_PC);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);

    // Directed table followed by random traffic
    target = N_DIR + 40;
    for (int t = 0; t < 5000 && accepts < target; t++) @(negedge clk);
    chk("phase1_accepts", 32'(accepts >= target), 32'd1);

    // Asynchronous reset in the middle of a FETCH cycle
    for (int t = 0; t < 200 && !imem_req; t++) @(negedge clk);
    chk("found_fetch", {31'd0, imem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_addr", imem_addr, RST_PC);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    addr_q.delete();
    busy = 0;
    imem_ack = 1'b0;
    addr_q.push_back(RST_PC);
    #2 reset = 1'b0;

    target = accepts + 30;
    for (int t = 0; t < 5000 && accepts < target; t++) @(negedge clk);
    chk("phase2_accepts", 32'(accepts >= target), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the controller/decoder.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers the returned instruction and presents it, with op/funct split out, under a valid/ready handshake.
- On acceptance, computes the next PC from pcsrc/jump, which the controller produces for that same instruction.

Parameters:
WIDTH, 32, datapath/address width in bits (only 32 supported)
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch byte address (= pc, bits[1:0] always 00)
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  WIDTH  instruction word, valid when imem_ack=1
instr_valid  output  1  instr/op/funct hold a fetched instruction
instr_ready  input  1  consumer accepts the instruction this cycle
instr  output  WIDTH  registered instruction word
op  output  6  instr[31:26]
funct  output  6  instr[5:0]
pc  output  WIDTH  address of the instruction in instr
pcplus4  output  WIDTH  pc + 4
pcsrc  input  1  branch taken for the current instruction (controller output)
jump  input  1  jump for the current instruction (controller output)

Behaviour:
- States: IDLE, FETCH, ISSUE.
- Reset (asynchronous, active-high):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0.
  - Any outstanding fetch is abandoned; an ack arriving during reset or in IDLE is ignored.
- IDLE: unconditional transition to FETCH on the first clk edge after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Requests are Moore outputs (decoded from state only).
  - On an edge with imem_ack=1: instr<=imem_rdata, state<=ISSUE.
  - Otherwise stay in FETCH with req held and addr stable.
  - A 0-wait memory (ack in the first FETCH cycle) is legal: minimum fetch = 1 cycle in FETCH + 1 cycle in ISSUE.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - instr, op, funct, pc and pcplus4 are stable until acceptance.
  - On an edge with instr_ready=1: pc<=next_pc, state<=FETCH.
  - If instr_ready=0: hold everything; no new request is issued.
- imem_ack outside FETCH is ignored; instr is not overwritten.
- pcsrc/jump are sampled only on the accepting edge (ISSUE and instr_ready=1).
- next_pc, all arithmetic modulo 2^32:
  - signimm = sign-extend instr[15:0] to 32 bits.
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}. jump has priority over pcsrc.
  - else pcsrc=1: pcplus4 + (signimm << 2).
  - else: pcplus4.
- Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; no error flagged.
- Throughput: one instruction per 2 cycles minimum with a 0-wait memory and instr_ready held high.
- No speculation; at most one fetch outstanding.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_ADDI 001000, OP_J 000010), fetch state encoding (IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2), default RESET_PC.
- One combinational sub-module: pc_next (inputs pc, instr, pcsrc, jump; outputs pcplus4, next_pc). It is reused by a later single-cycle variant.
- The state register, pc register and instr register stay in ifetch_unit.

Test Plan:
1. Reset, then release with 0-wait memory and instr_ready=1:
   - imem_req=0 during reset.
   - imem_req=1 with imem_addr=0x0 on the first cycle after the first post-reset edge.
   - Successive addresses 0x0, 0x4, 0x8 every 2 cycles.
2. Memory ack delayed by 3 cycles:
   - imem_req and imem_addr are held stable for 3 cycles.
   - instr equals imem_rdata captured at the ack edge.
   - Spurious ack during ISSUE does not change instr.
3. BEQ at pc=0x8 with instr[15:0]=0x0003, pcsrc=1 at accept: next fetch address 0x18.
   - Repeat with imm=0xFFFF: next fetch address 0x8.
   - Repeat with pcsrc=0: next fetch address 0xC.
4. Jump and priority:
   - instr=0x0800_0010 at pc=0x0, jump=1: next fetch address 0x40.
   - Same instruction with jump=1 and pcsrc=1: still 0x40.
5. Backpressure: instr_ready=0 for 4 cycles in ISSUE:
   - instr_valid=1 and instr/op/funct/pc unchanged throughout.
   - imem_req=0 throughout.
   - Accept on the 5th cycle; the next request follows on the next cycle.
6. Reset mid-operation and wrap:
   - Assert reset asynchronously while in FETCH (between edges): imem_req drops immediately, pc=RESET_PC.
   - Separately, force a sequential fetch from 0xFFFF_FFFC: next address 0x0.
